tgl_hs_rx: RTL and testbench

Toggle-handshake receiver: the responder end of the team's two-wire toggle protocol, whose initiator flips `req_t` once per word and waits for `ack_t` to flip back. The block detects each request toggle, captures `din` into a small FIFO and answers with a T-flip-flop style `ack_t` toggle. Buffered words are presented downstream on a valid/ready port. It sits between a toggle-signalling producer and any standard streaming consumer in the datapath.

---
 rtl/tgl_hs_rx.sv | 85 ++++++++
 tb/tb_tgl_hs_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tgl_hs_rx.sv
// rtl/tgl_hs_rx.sv - toggle-handshake receiver: toggle detect, word FIFO, ack toggle, valid/ready output
// Optional macro TGL_HS_RX_SYNC_EN adds a two-flop synchronizer on req_t.
module tgl_hs_rx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_t,
  input  logic [WIDTH-1:0] din,
  output logic             ack_t,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [LW-1:0]    level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             req_s;
  logic             req_prev;
  logic             req_edge;
  logic             pop;
  logic             accept;

`ifdef TGL_HS_RX_SYNC_EN
  logic [1:0] req_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_sync <= '0;
    end else begin
      req_sync <= {req_sync[0], req_t};
    end
  end

  assign req_s = req_sync[1];
`else
  assign req_s = req_t;
`endif

  // A pending edge that cannot be accepted is the HOLD condition: req_prev
  // stays behind req_s, so the edge is retried every cycle until space frees.
  assign req_edge   = req_s ^ req_prev;
  assign dout_valid = (level != '0);
  assign pop        = dout_valid && dout_ready;
  assign accept     = req_edge && ((level < LW'(DEPTH)) || pop);
  assign dout       = dout_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_t    <= 1'b0;
      req_prev <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
    end else begin
      if (accept) begin
        wr_ptr   <= wr_ptr + 1'b1;
        req_prev <= req_s;
        ack_t    <= ~ack_t;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset; dout is masked by dout_valid instead.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: tb/tb_tgl_hs_rx.sv
// tb/tb_tgl_hs_rx.sv - self-checking bench for tgl_hs_rx
// Table vectors, hand sequences and random traffic against a queue-based model.
module tb_tgl_hs_rx;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef TGL_HS_RX_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req_t;
  logic [WIDTH-1:0] din;
  logic             ack_t;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [LW-1:0]    level;

  tgl_hs_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LW(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_t      (req_t),
    .din        (din),
    .ack_t      (ack_t),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .level      (level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model: a word queue, the acknowledge parity and the
  // request as seen after the optional synchronizer delay.
  logic [WIDTH-1:0] mq[$];
  logic             m_ack = 1'b0;
  logic             d0 = 1'b0;
  logic             d1 = 1'b0;

  function automatic void chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_edge();
    logic rs;
    logic m_pop;
    logic m_acc;
    if (rst) begin
      mq.delete();
      m_ack = 1'b0;
      d0 = 1'b0;
      d1 = 1'b0;
    end else begin
      rs    = SYNC ? d1 : req_t;
      m_pop = (mq.size() > 0) && dout_ready;
      m_acc = (rs != m_ack) && ((mq.size() < DEPTH) || m_pop);
      if (m_pop) void'(mq.pop_front());
      if (m_acc) begin
        mq.push_back(din);
        m_ack = ~m_ack;
      end
      d1 = d0;
      d0 = req_t;
    end
  endfunction

  function automatic void model_check();
    chk("ack_t", int'(ack_t), int'(m_ack));
    chk("level", int'(level), mq.size());
    chk("dout_valid", int'(dout_valid), int'(mq.size() > 0));
    chk("dout", int'(dout), (mq.size() > 0) ? int'(mq[0]) : 0);
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  typedef struct {
    logic             rst;
    logic             req;
    logic [WIDTH-1:0] din;
    logic             rdy;
    logic             ack;
    logic             v;
    logic [WIDTH-1:0] d;
    int               lvl;
  } vec_t;

  vec_t             tbl[$];
  logic [WIDTH-1:0] got[$];
  int               n;

  task automatic step_collect();
    if (dout_valid && dout_ready) got.push_back(dout);
    step();
  endtask

  initial begin
    rst = 1'b1;
    req_t = 1'b0;
    din = '0;
    dout_ready = 1'b0;

    //               rst req din    rdy  ack v  dout  lvl
    tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0});
    tbl.push_back('{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1});
    tbl.push_back('{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1});
    tbl.push_back('{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 0});
    tbl.push_back('{1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 1});
    tbl.push_back('{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 2});
    tbl.push_back('{1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 3});
    tbl.push_back('{1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h01, 4});
    tbl.push_back('{1'b0, 1'b0, 8'h05, 1'b0, 1'b1, 1'b1, 8'h01, 4});
    tbl.push_back('{1'b0, 1'b0, 8'h05, 1'b0, 1'b1, 1'b1, 8'h01, 4});
    tbl.push_back('{1'b0, 1'b0, 8'h05, 1'b1, 1'b0, 1'b1, 8'h02, 4});
    tbl.push_back('{1'b0, 1'b0, 8'h05, 1'b1, 1'b0, 1'b1, 8'h03, 3});
    tbl.push_back('{1'b0, 1'b0, 8'h05, 1'b1, 1'b0, 1'b1, 8'h04, 2});
    tbl.push_back('{1'b0, 1'b0, 8'h05, 1'b1, 1'b0, 1'b1, 8'h05, 1});
    tbl.push_back('{1'b0, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0, 8'h00, 0});
    tbl.push_back('{1'b0, 1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 8'h66, 1});
    tbl.push_back('{1'b0, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 8'h00, 0});
    tbl.push_back('{1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 8'h77, 1});
    tbl.push_back('{1'b0, 1'b1, 8'h78, 1'b0, 1'b1, 1'b1, 8'h77, 2});
    tbl.push_back('{1'b0, 1'b0, 8'h79, 1'b0, 1'b0, 1'b1, 8'h77, 3});
    tbl.push_back('{1'b1, 1'b1, 8'h7A, 1'b0, 1'b0, 1'b0, 8'h00, 0});
    tbl.push_back('{1'b0, 1'b0, 8'h7A, 1'b0, 1'b0, 1'b0, 8'h00, 0});

    foreach (tbl[i]) begin
      rst        = tbl[i].rst;
      req_t      = tbl[i].req;
      din        = tbl[i].din;
      dout_ready = tbl[i].rdy;
      step();
`ifndef TGL_HS_RX_SYNC_EN
      chk($sformatf("tbl%0d_ack", i), int'(ack_t), int'(tbl[i].ack));
      chk($sformatf("tbl%0d_valid", i), int'(dout_valid), int'(tbl[i].v));
      chk($sformatf("tbl%0d_dout", i), int'(dout), int'(tbl[i].d));
      chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].lvl);
`endif
    end

    // Let any synchronizer state settle before the streaming sequence.
    for (int i = 0; i < 4; i++) step();

    // Wrap-around: ten words through a four-deep FIFO with the consumer always ready.
    dout_ready = 1'b1;
    got.delete();
    for (int w = 0; w < 10; w++) begin
      din   = 8'h10 + 8'(w);
      req_t = ~req_t;
      n = 0;
      while (ack_t != req_t && n <= 20) begin
        step_collect();
        n++;
      end
      chk($sformatf("wrap_ack_w%0d_in_time", w), int'(n <= 20), 1);
    end
    for (int i = 0; i < 4; i++) step_collect();
    chk("wrap_count", got.size(), 10);
    foreach (got[i]) chk($sformatf("wrap_word%0d", i), int'(got[i]), 8'h10 + i);
    chk("wrap_level_end", int'(level), 0);

    // Random traffic: a protocol-abiding initiator and a random consumer.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst   = 1'b1;
        req_t = 1'b0;
      end else begin
        rst = 1'b0;
        if (req_t == ack_t && $urandom_range(0, 2) == 0) begin
          req_t = ~req_t;
          din   = WIDTH'($urandom);
        end
      end
      dout_ready = ($urandom_range(0, 3) != 0) && (c % 200 < 150);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
